// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader.
package loader_pkg;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE} loader_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, framing-error report.
// byte_valid and frame_err are single-cycle pulses; byte_data holds the last byte.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rxd,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t         state, state_n;
  logic              sync1, rx;
  logic [CW-1:0]     cnt, cnt_n;
  logic [2:0]        bit_idx, bit_n;
  logic [BYTE_W-1:0] shreg, sh_n;
  logic              valid_n, ferr_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 1'b1;
      rx         <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rxd;
      rx         <= sync1;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= sh_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  // The start bit is re-checked half a bit in; every later sample lands mid-bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    sh_n    = shreg;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (!rx) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          sh_n  = {rx, shreg[BYTE_W-1:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          if (rx) begin
            valid_n = 1'b1;
            state_n = RX_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = RX_WAIT_HI;
          end
        end
      end
      RX_WAIT_HI: begin
        cnt_n = '0;
        if (rx) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign byte_data = shreg;
endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives a length-prefixed image over UART, writes it as
// little-endian 32-bit words, and releases the core once the image is in.
module uart_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int MAX_WORDS    = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rxd,
  output logic              mem_we,
  output logic [31:0]       mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int IW = $clog2(MAX_WORDS) + 1;

  logic              byte_valid, frame_err;
  logic [BYTE_W-1:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  loader_state_t     state, state_n;
  logic [1:0]        byte_cnt;
  logic [31:0]       len;
  logic [IW-1:0]     word_idx;
  logic [23:0]       word_lo;
  logic [31:0]       len_full;
  logic              last_byte, too_long, last_word;

  assign len_full  = {byte_data, len[31:8]};
  assign last_byte = byte_valid && (byte_cnt == 2'd3);
  assign too_long  = len_full > 32'(MAX_WORDS);
  assign last_word = 32'(word_idx) == (len - 32'd1);

  always_comb begin
    state_n = state;
    case (state)
      S_LEN:   if (last_byte) state_n = ((len_full == 32'd0) || too_long) ? S_DONE : S_DATA;
      S_DATA:  if (last_byte && last_word) state_n = S_DONE;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_LEN;
      byte_cnt     <= '0;
      len          <= '0;
      word_idx     <= '0;
      word_lo      <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      core_reset_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      mem_we       <= 1'b0;
      done         <= (state_n == S_DONE) && (state != S_DONE);
      core_reset_n <= (state_n == S_DONE);
      busy         <= (state_n != S_DONE) && (busy || byte_valid);
      err          <= err || frame_err || ((state == S_LEN) && last_byte && too_long);
      if (byte_valid && (state != S_DONE)) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_LEN) begin
          len <= len_full;
        end else if (byte_cnt == 2'd3) begin
          mem_we    <= 1'b1;
          mem_waddr <= 32'({word_idx, 2'b00});
          mem_wdata <= {byte_data, word_lo};
          word_idx  <= word_idx + IW'(1);
        end else begin
          word_lo[{byte_cnt, 3'b000} +: BYTE_W] <= byte_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: a serial driver feeds directed and random
// images, and an image-level model predicts writes, done, busy, err and core release.
module tb_uart_loader;
  localparam int CPB  = 16;
  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rxd = 1'b1;
  logic        mem_we, core_reset_n, busy, done, err;
  logic [31:0] mem_waddr, mem_wdata;

  always #5 clk = ~clk;

  uart_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rxd         (rxd),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .core_reset_n(core_reset_n),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          done_base, wr_base;
  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  tx_q[$];
  bit          bad_q[$];
  bit          err_exp, done_exp, busy_exp;

  // Observed write stream and done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_waddr, mem_wdata});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_ok;
    tick(CPB);
    rxd = 1'b1;
    tick(stop_ok ? 4 : CPB);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"},   64'(mem_we),       64'd0);
    chk({tag, "_addr"}, 64'(mem_waddr),    64'd0);
    chk({tag, "_data"}, 64'(mem_wdata),    64'd0);
    chk({tag, "_core"}, 64'(core_reset_n), 64'd0);
    chk({tag, "_busy"}, 64'(busy),         64'd0);
    chk({tag, "_done"}, 64'(done),         64'd0);
    chk({tag, "_err"},  64'(err),          64'd0);
  endtask

  // Image-level model: drop bad-stop bytes, read N, then slice N words out.
  task automatic build_model();
    logic [7:0]  g[$];
    logic [31:0] n;
    exp_q.delete();
    err_exp = 1'b0;
    foreach (tx_q[i]) begin
      if (bad_q[i]) err_exp = 1'b1;
      else g.push_back(tx_q[i]);
    end
    done_exp = 1'b0;
    busy_exp = g.size() > 0;
    if (g.size() >= 4) begin
      n = {g[3], g[2], g[1], g[0]};
      if (n == 0 || n > MAXW) begin
        if (n > MAXW) err_exp = 1'b1;
        done_exp = 1'b1;
      end else begin
        for (int w = 0; w < int'(n); w++)
          if (4 * w + 7 < g.size())
            exp_q.push_back({32'(w * 4), g[4*w+7], g[4*w+6], g[4*w+5], g[4*w+4]});
        done_exp = g.size() >= 4 + 4 * int'(n);
      end
    end
    if (done_exp) busy_exp = 1'b0;
  endtask

  task automatic run_case(input string tag);
    wr_base   = wr_q.size();
    done_base = done_cnt;
    build_model();
    foreach (tx_q[i]) send_byte(tx_q[i], !bad_q[i]);
    tick(30);
    chk({tag, "_nwr"}, 64'(wr_q.size() - wr_base), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (wr_base + i < wr_q.size())
        chk($sformatf("%s_wr%0d", tag, i), wr_q[wr_base+i], exp_q[i]);
    chk({tag, "_done"}, 64'(done_cnt - done_base), 64'(done_exp));
    chk({tag, "_core"}, 64'(core_reset_n), 64'(done_exp));
    chk({tag, "_busy"}, 64'(busy), 64'(busy_exp));
    chk({tag, "_err"},  64'(err), 64'(err_exp));
  endtask

  task automatic load(input logic [7:0] b[$]);
    tx_q = b;
    bad_q.delete();
    foreach (b[i]) bad_q.push_back(1'b0);
  endtask

  initial begin
    logic [31:0] n;
    logic [7:0]  b[$];
    reset_n = 1'b0;
    tick(2);
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick(2);

    // Two-word image; busy must rise on the first length byte.
    send_byte(8'h02, 1'b1);
    chk("t1_busy_early", 64'(busy), 64'd1);
    chk("t1_core_early", 64'(core_reset_n), 64'd0);
    apply_reset();
    load('{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE});
    run_case("t1");

    apply_reset();
    load('{8'h00, 8'h00, 8'h00, 8'h00});
    run_case("t2_zero");

    apply_reset();
    load('{8'h09, 8'h00, 8'h00, 8'h00});
    run_case("t3_over");

    // Glitch in idle, then a frame with a bad stop bit inside a one-word image.
    apply_reset();
    wr_base = wr_q.size();
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    chk("t4_glitch_busy", 64'(busy), 64'd0);
    chk("t4_glitch_nwr", 64'(wr_q.size() - wr_base), 64'd0);
    load('{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44});
    bad_q[4] = 1'b1;
    run_case("t4_ferr");

    // Reset in the middle of the second word, then a fresh load.
    apply_reset();
    load('{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE});
    run_case("t5_part");
    reset_n = 1'b0;
    #1;
    check_reset_vals("t5_midrst");
    tick(3);
    reset_n = 1'b1;
    tick(2);
    load('{8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B});
    run_case("t5_reload");

    // Traffic after done is ignored.
    wr_base   = wr_q.size();
    done_base = done_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'hC3, 1'b1);
    tick(30);
    chk("t6_nwr", 64'(wr_q.size() - wr_base), 64'd0);
    chk("t6_done", 64'(done_cnt - done_base), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_core", 64'(core_reset_n), 64'd1);

    for (int k = 0; k < 3; k++) begin
      apply_reset();
      n = 32'($urandom_range(1, MAXW));
      b.delete();
      for (int i = 0; i < 4; i++) b.push_back(n[8*i +: 8]);
      for (int i = 0; i < 4 * int'(n); i++) b.push_back(8'($urandom_range(0, 255)));
      load(b);
      run_case($sformatf("rnd%0d", k));
    end

    apply_reset();
    n = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
         8'($urandom_range(0, 255)), 8'($urandom_range(MAXW + 1, 255))};
    b.delete();
    for (int i = 0; i < 4; i++) b.push_back(n[8*i +: 8]);
    load(b);
    run_case("rnd_over");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
